slice_add_seq: RTL and testbench

//  Multi-cycle WIDTH-bit add/subtract unit built around one SLICE-bit ripple-carry adder datapath.

---
 rtl/slice_add_seq.sv | 98 +++++++++
 tb/tb_slice_add_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/slice_add_seq.sv
// Multi-cycle WIDTH-bit add/subtract unit. One SLICE-bit ripple-carry adder
// is reused once per slice, LSB slice first, with the carry registered
// between passes. Valid/ready handshake on both the operand and result sides.
module slice_add_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int NS = WIDTH / SLICE;
  localparam int IW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry;
  logic [IW-1:0]    idx;
  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE-1:0] s_sl;
  logic             cy;
  logic             last;
  logic             accept;

  // Select the current slice of the latched operands
  assign a_sl = a_q[idx*SLICE +: SLICE];
  assign b_sl = b_q[idx*SLICE +: SLICE];

  // Shared SLICE-bit adder with incoming carry
  always_comb begin
    {cy, s_sl} = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry};
  end

  assign last      = (idx == IW'(NS - 1));
  assign in_ready  = (state == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = CALC;
      CALC:    if (last) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture and per-slice result accumulation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= sub ? ~b : b;
      carry <= sub;
      idx   <= '0;
    end else if (state == CALC) begin
      sum[idx*SLICE +: SLICE] <= s_sl;
      carry <= cy;
      idx   <= idx + 1'b1;
      if (last) begin
        c_out <= cy;
        // carry into the MSB is recovered from the MSB sum bit
        ovf   <= (a_sl[SLICE-1] ^ b_sl[SLICE-1] ^ s_sl[SLICE-1]) ^ cy;
      end
    end
  end

endmodule

// File: tb/tb_slice_add_seq.sv
// Directed and randomized self-checking bench for slice_add_seq (32/16).
module tb_slice_add_seq;

  localparam int WIDTH = 32;
  localparam int SLICE = 16;
  localparam int NS    = WIDTH / SLICE;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  int checks = 0;
  int errors = 0;
  int n_in   = 0;
  int n_out  = 0;

  slice_add_seq #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (!in_ready) check({tag, "_rdy_timeout"}, 0, 1);
  endtask

  task automatic wait_valid(input string tag, output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    if (!out_valid) check({tag, "_valid_timeout"}, 0, 1);
  endtask

  // Full transaction: accept, latency, result, backpressure hold, drain
  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic ts, input int hold, input int gap,
                        input logic [31:0] es, input logic ec, input logic eo,
                        input logic chk_lat);
    int lat;
    repeat (gap) tick();
    wait_ready(tag);
    a = ta; b = tb_v; sub = ts; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_in++;
    wait_valid(tag, lat);
    if (chk_lat) check({tag, "_lat"}, lat, NS);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, c_out, ec);
    check({tag, "_ovf"}, ovf, eo);
    if (chk_lat) check({tag, "_inrdy"}, in_ready, 0);
    repeat (hold) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_out++;
    if (chk_lat) check({tag, "_vld_clr"}, out_valid, 0);
  endtask

  initial begin
    logic [31:0] ra, rb, bb, es;
    logic        rs, ec, eo;
    logic [32:0] full;
    int          lat;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0;
    #1;
    check("rst_inrdy", in_ready, 0);
    check("rst_vld", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_flags", {c_out, ovf}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick();
    check("idle_inrdy", in_ready, 1);

    run_op("t1",   32'h0000FFFF, 32'h00000001, 1'b0, 0, 0, 32'h00010000, 1'b0, 1'b0, 1'b1);
    run_op("t2a",  32'hFFFFFFFF, 32'h00000001, 1'b0, 0, 0, 32'h00000000, 1'b1, 1'b0, 1'b1);
    run_op("t2b",  32'h7FFFFFFF, 32'h00000001, 1'b0, 0, 0, 32'h80000000, 1'b0, 1'b1, 1'b1);
    run_op("t3a",  32'h00000005, 32'h00000007, 1'b1, 0, 0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1);
    run_op("t3b",  32'h80000000, 32'h00000001, 1'b1, 0, 0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b1);
    run_op("t3c",  32'h80000000, 32'h80000000, 1'b0, 0, 0, 32'h00000000, 1'b1, 1'b1, 1'b1);
    run_op("t3d",  32'h00000000, 32'h00000000, 1'b1, 0, 0, 32'h00000000, 1'b1, 1'b0, 1'b1);
    run_op("t3e",  32'h0001FFFF, 32'h00010000, 1'b1, 0, 0, 32'h0000FFFF, 1'b1, 1'b0, 1'b1);

    // Backpressure: result held 5 cycles while new bundles are offered
    wait_ready("bp");
    a = 32'hAAAA5555; b = 32'h11111111; sub = 1'b0; in_valid = 1'b1;
    tick();
    n_in++;
    a = 32'h00000001; b = 32'h00000001;
    wait_valid("bp", lat);
    for (int i = 0; i < 5; i++) begin
      check("bp_vld", out_valid, 1);
      check("bp_sum", sum, 32'hBBBB6666);
      check("bp_flags", {c_out, ovf}, 2'b00);
      check("bp_inrdy", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_out++;
    check("bp_idle_rdy", in_ready, 1);
    check("bp_idle_vld", out_valid, 0);
    tick();
    in_valid = 1'b0;
    n_in++;
    wait_valid("bp2", lat);
    check("bp2_lat", lat, NS);
    check("bp2_sum", sum, 32'h00000002);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_out++;

    // Reset during CALC
    wait_ready("rc");
    a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rc_vld", out_valid, 0);
    check("rc_sum", sum, 0);
    check("rc_flags", {c_out, ovf}, 0);
    check("rc_inrdy", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin tick(); check("rc_novld", out_valid, 0); end

    // Reset during DONE
    wait_ready("rd");
    a = 32'h7FFFFFFF; b = 32'h7FFFFFFF; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid("rd", lat);
    check("rd_sum_pre", sum, 32'hFFFFFFFE);
    rst = 1'b1;
    #1;
    check("rd_vld", out_valid, 0);
    check("rd_sum", sum, 0);
    check("rd_flags", {c_out, ovf}, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("rd_novld", out_valid, 0);

    run_op("t5", 32'h12345678, 32'h11111111, 1'b0, 0, 0, 32'h23456789, 1'b0, 1'b0, 1'b1);

    // Randomized operations against a 33-bit reference and sign-rule overflow
    for (int i = 0; i < 3000; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      if (i % 7 == 0) ra = 32'h7FFFFFFF;
      if (i % 11 == 0) rb = 32'hFFFFFFFF;
      bb   = rs ? ~rb : rb;
      full = {1'b0, ra} + {1'b0, bb} + {32'b0, rs};
      es   = full[31:0];
      ec   = full[32];
      eo   = (ra[31] == bb[31]) && (es[31] != ra[31]);
      run_op("rnd", ra, rb, rs, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
             es, ec, eo, 1'b0);
    end
    check("io_count", n_out, n_in);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
